mine_board_ctrl: RTL and testbench
==================================

Name: mine_board_ctrl

Overview:
- Parametrised successor of the board controller for the minesweeper game.
- Holds the COLS x ROWS cell-state array and computes neighbour counts sequentially from a latched mine map.
- Owns the cursor, a true stack-based flood-fill reveal, flagging, and win/lose detection.
- Sits between the debounced button/switch inputs and the display scanner, which reads cells through a random-access read port.

Parameters:
- COLS, 10, board width in cells (2..15).
- ROWS, 10, board height in cells (2..15).
- N, COLS*ROWS, cell count (derived; do not override).
- AW, $clog2(N), cell index width (derived).

Ports:
- clk_1ms  in  1  game clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; rising edge latches mines_in and begins a new game.
- mines_in  in  N  mine map, bit i = cell i (i = y*COLS + x).
- left, right, up, down  in  1 each  cursor buttons, level; rising edges act.
- stamp  in  1  reveal button, level; rising edge acts.
- mark  in  1  flag toggle, level; rising edge acts.
- rd_x, rd_y  in  4 each  display read coordinate.
- rd_state  out  4  cell code at (rd_x, rd_y), combinational.
- posx, posy  out  4 each  cursor.
- state  out  3  IDLE=0, COUNT=1, PLAY=2, FLOOD=3, LOSE=4, WIN=5.
- busy  out  1  high in COUNT or FLOOD.
- revealed  out  AW+1  number of revealed safe cells.

Behaviour:
- Cell codes: 0 hidden, 1..9 revealed with neighbour count+1, 10 flag, 11 mine (display only).
- Reset: state=IDLE, posx=posy=0, revealed=0, all cells 0, stack empty, edge-detect registers 0.
- Edge detect: each button has a registered copy; edge = in & ~old; copies update every cycle in every state.
- IDLE -> COUNT on start edge. On that transition: latch mines_in, clear cells, revealed, cursor and stack.
- start edge in any other state also restarts the game this way.
- COUNT: one cell per cycle, index 0..N-1, count = sum of the up-to-8 in-board neighbours (board edges clipped, no wrap). Exactly N cycles, then PLAY.
- PLAY, cursor: one move per cycle, priority left > right > up > down. Wraps: x 0 -> COLS-1 on left, COLS-1 -> 0 on right; y likewise with ROWS.
- PLAY, stamp on a code-0 cell:
  - Mine: go to LOSE.
  - Count>0: write count+1, revealed+1.
  - Count=0: write 1, revealed+1, push index, go to FLOOD.
- PLAY, stamp on a flag or revealed cell: ignored.
- PLAY, mark: toggles 0 <-> 10 at the cursor; other codes unchanged. Stamp and mark in the same cycle: stamp wins, mark dropped.
- FLOOD: pop one index, then visit its 8 neighbours, one per cycle. Each in-board neighbour with code 0 and no mine: write count+1, revealed+1, push if count=0.
  - Flags are not cleared by flood.
  - A cell is written before it is pushed, so stack depth N never overflows.
  - Stack empty after the last neighbour -> PLAY. All button edges in FLOOD are dropped.
- Win check: in PLAY, revealed == N - popcount(latched mines) -> WIN next cycle; also checked on leaving FLOOD.
- LOSE: rd_state returns 11 for every mined cell, stored code otherwise. Stays until a start edge.
- WIN: stores nothing new. rd_state returns stored codes. Stays until a start edge.
- rd_x >= COLS or rd_y >= ROWS: rd_state = 0.
- reset during FLOOD or COUNT: immediate abort to reset values.

Optional Feature:
- FLAG_LIMIT_EN defined: adds output flags_left (AW+1). Loaded with the mine popcount at start, decremented on flag set, incremented on flag clear. Flag set is refused when flags_left=0.
- Undefined: port absent; flags are unlimited.

Test Plan:
- Reset, then start with mines_in bit 0 only -> COUNT lasts exactly 100 cycles; rd_state at (1,1) = 2, at (9,9) = 0 after stamping there.
- Mine at cell 0, stamp at (9,9) -> FLOOD reveals all 99 safe cells, revealed=99, state WIN.
- Mines at 0, 15, 27, cursor left from (0,0) -> posx=9; stamp at (5,1) -> LOSE, rd_state(0,0)=11.
- mark at (3,3) twice -> code 10 then 0; stamp on the flagged cell -> no change.
- Wall of mines on column 5, stamp at (0,0) -> reveal stops at column 4, flag placed at (2,2) beforehand stays 10.
- Assert reset mid-FLOOD -> next cycle state=0, revealed=0, all rd_state=0.

Source files
------------

// File: rtl/mine_board_ctrl.sv
// Minesweeper board controller: cell array, sequential neighbour counting, cursor,
// stack-based flood reveal, flags and win/lose detection. Optional FLAG_LIMIT_EN adds flags_left.
module mine_board_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 10,
    parameter int N    = COLS * ROWS,
    parameter int AW   = $clog2(N)
) (
    input  logic          clk_1ms,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  mines_in,
    input  logic          left,
    input  logic          right,
    input  logic          up,
    input  logic          down,
    input  logic          stamp,
    input  logic          mark,
    input  logic [3:0]    rd_x,
    input  logic [3:0]    rd_y,
    output logic [3:0]    rd_state,
    output logic [3:0]    posx,
    output logic [3:0]    posy,
    output logic [2:0]    state,
    output logic          busy,
`ifdef FLAG_LIMIT_EN
    output logic [AW:0]   flags_left,
`endif
    output logic [AW:0]   revealed
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_COUNT = 3'd1, S_PLAY = 3'd2,
        S_FLOOD = 3'd3, S_LOSE = 3'd4, S_WIN = 3'd5
    } state_t;

    localparam logic [3:0] L_XMAX = 4'(COLS - 1);
    localparam logic [3:0] L_YMAX = 4'(ROWS - 1);
    localparam logic [AW:0] L_N   = (AW + 1)'(N);

    state_t        r_state, w_state_n;
    logic [N-1:0]  r_mines;
    logic [3:0]    r_cells [N];
    logic [3:0]    r_cnt   [N];
    logic [7:0]    r_stack [N];
    logic [AW:0]   r_sp, r_rev, r_safe;
    logic [3:0]    r_px, r_py, r_cx, r_cy, r_fx, r_fy, r_nb;
    logic          r_start_d, r_left_d, r_right_d, r_up_d, r_down_d, r_stamp_d, r_mark_d;
`ifdef FLAG_LIMIT_EN
    logic [AW:0]   r_flags;
`endif

    function automatic logic [AW-1:0] f_idx(input int x, input int y);
        int t;
        t = y * COLS + x;
        return t[AW-1:0];
    endfunction

    function automatic logic [3:0] f_count(input logic [N-1:0] m, input int x, input int y);
        logic [3:0] c;
        c = '0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < COLS &&
                    y + dy >= 0 && y + dy < ROWS && m[f_idx(x + dx, y + dy)])
                    c = c + 4'd1;
        return c;
    endfunction

    function automatic logic [AW:0] f_popcount(input logic [N-1:0] m);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < N; i++)
            if (m[i]) c = c + 1'b1;
        return c;
    endfunction

    logic w_e_start, w_e_left, w_e_right, w_e_up, w_e_down, w_e_stamp, w_e_mark;
    assign w_e_start = start & ~r_start_d;
    assign w_e_left  = left  & ~r_left_d;
    assign w_e_right = right & ~r_right_d;
    assign w_e_up    = up    & ~r_up_d;
    assign w_e_down  = down  & ~r_down_d;
    assign w_e_stamp = stamp & ~r_stamp_d;
    assign w_e_mark  = mark  & ~r_mark_d;

    // Flood neighbour k = r_nb-1 around (r_fx, r_fy); r_nb == 0 is the pop cycle
    int            w_dx, w_dy, w_nx, w_ny;
    logic          w_nin;
    logic [AW-1:0] w_nidx;
    logic [3:0]    w_nx4, w_ny4;
    always_comb begin
        w_dx = 0;
        w_dy = 0;
        case (r_nb)
            4'd1: begin w_dx = -1; w_dy = -1; end
            4'd2: begin w_dx =  0; w_dy = -1; end
            4'd3: begin w_dx =  1; w_dy = -1; end
            4'd4: begin w_dx = -1; w_dy =  0; end
            4'd5: begin w_dx =  1; w_dy =  0; end
            4'd6: begin w_dx = -1; w_dy =  1; end
            4'd7: begin w_dx =  0; w_dy =  1; end
            4'd8: begin w_dx =  1; w_dy =  1; end
            default: ;
        endcase
        w_nx   = int'(r_fx) + w_dx;
        w_ny   = int'(r_fy) + w_dy;
        w_nin  = (r_nb != 4'd0) && w_nx >= 0 && w_nx < COLS && w_ny >= 0 && w_ny < ROWS;
        w_nidx = w_nin ? f_idx(w_nx, w_ny) : '0;
        w_nx4  = w_nx[3:0];
        w_ny4  = w_ny[3:0];
    end

    logic [AW-1:0] w_pidx, w_cidx, w_ridx;
    logic [3:0]    w_pcode, w_pcnt;
    logic          w_pmine, w_rin;
    assign w_pidx  = f_idx(int'(r_px), int'(r_py));
    assign w_cidx  = f_idx(int'(r_cx), int'(r_cy));
    assign w_pcode = r_cells[w_pidx];
    assign w_pcnt  = r_cnt[w_pidx];
    assign w_pmine = r_mines[w_pidx];
    assign w_rin   = (int'(rd_x) < COLS) && (int'(rd_y) < ROWS);
    assign w_ridx  = w_rin ? f_idx(int'(rd_x), int'(rd_y)) : '0;

    logic        w_win, w_act, w_stamp_go, w_mark_go, w_fl, w_fl_wr, w_fl_push, w_fl_done;
    logic        w_count_last, w_flag_ok;
    logic [AW:0] w_rev_after, w_spm1;
`ifdef FLAG_LIMIT_EN
    assign w_flag_ok = (r_flags != '0);
`else
    assign w_flag_ok = 1'b1;
`endif
    assign w_win        = (r_state == S_PLAY) && (r_rev == r_safe);
    assign w_act        = (r_state == S_PLAY) && !w_e_start && !w_win;
    assign w_stamp_go   = w_act && w_e_stamp && (w_pcode == 4'd0);
    assign w_mark_go    = w_act && w_e_mark && !w_e_stamp &&
                          ((w_pcode == 4'd10) || (w_pcode == 4'd0 && w_flag_ok));
    assign w_fl         = (r_state == S_FLOOD) && !w_e_start;
    assign w_fl_wr      = w_fl && w_nin && (r_cells[w_nidx] == 4'd0) && !r_mines[w_nidx];
    assign w_fl_push    = w_fl_wr && (r_cnt[w_nidx] == 4'd0);
    assign w_fl_done    = w_fl && (r_nb == 4'd8) && (r_sp == '0) && !w_fl_push;
    assign w_rev_after  = r_rev + {{AW{1'b0}}, w_fl_wr};
    assign w_spm1       = r_sp - 1'b1;
    assign w_count_last = (r_cx == L_XMAX) && (r_cy == L_YMAX);

    always_comb begin
        w_state_n = r_state;
        if (w_e_start) begin
            w_state_n = S_COUNT;
        end else begin
            case (r_state)
                S_COUNT: if (w_count_last) w_state_n = S_PLAY;
                S_PLAY: begin
                    if (w_win)                          w_state_n = S_WIN;
                    else if (w_stamp_go && w_pmine)     w_state_n = S_LOSE;
                    else if (w_stamp_go && w_pcnt == 0) w_state_n = S_FLOOD;
                end
                S_FLOOD: if (w_fl_done) w_state_n = (w_rev_after == r_safe) ? S_WIN : S_PLAY;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            {r_start_d, r_left_d, r_right_d, r_up_d, r_down_d, r_stamp_d, r_mark_d} <= '0;
            r_mines <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_nb    <= '0;
            r_sp    <= '0;
            r_rev   <= '0;
            r_safe  <= '0;
            for (int i = 0; i < N; i++) r_cells[i] <= 4'd0;
`ifdef FLAG_LIMIT_EN
            r_flags <= '0;
`endif
        end else begin
            {r_start_d, r_left_d, r_right_d, r_up_d, r_down_d, r_stamp_d, r_mark_d} <=
                {start, left, right, up, down, stamp, mark};
            if (w_e_start) begin
                r_mines <= mines_in;
                r_px    <= '0;
                r_py    <= '0;
                r_cx    <= '0;
                r_cy    <= '0;
                r_nb    <= '0;
                r_sp    <= '0;
                r_rev   <= '0;
                r_safe  <= L_N - f_popcount(mines_in);
                for (int i = 0; i < N; i++) r_cells[i] <= 4'd0;
`ifdef FLAG_LIMIT_EN
                r_flags <= f_popcount(mines_in);
`endif
            end else begin
                case (r_state)
                    S_COUNT: begin
                        if (r_cx == L_XMAX) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 4'd1;
                        end else begin
                            r_cx <= r_cx + 4'd1;
                        end
                    end
                    S_PLAY: begin
                        if (w_act) begin
                            if (w_e_left)       r_px <= (r_px == 4'd0)   ? L_XMAX : r_px - 4'd1;
                            else if (w_e_right) r_px <= (r_px == L_XMAX) ? 4'd0   : r_px + 4'd1;
                            else if (w_e_up)    r_py <= (r_py == 4'd0)   ? L_YMAX : r_py - 4'd1;
                            else if (w_e_down)  r_py <= (r_py == L_YMAX) ? 4'd0   : r_py + 4'd1;
                        end
                        if (w_stamp_go && !w_pmine) begin
                            r_cells[w_pidx] <= w_pcnt + 4'd1;
                            r_rev           <= r_rev + 1'b1;
                            if (w_pcnt == 4'd0) begin
                                r_fx <= r_px;
                                r_fy <= r_py;
                                r_nb <= 4'd0;
                                r_sp <= r_sp + 1'b1;
                            end
                        end
                        if (w_mark_go) begin
                            r_cells[w_pidx] <= (w_pcode == 4'd0) ? 4'd10 : 4'd0;
`ifdef FLAG_LIMIT_EN
                            r_flags <= (w_pcode == 4'd0) ? r_flags - 1'b1 : r_flags + 1'b1;
`endif
                        end
                    end
                    S_FLOOD: begin
                        if (r_nb == 4'd0) begin
                            r_sp         <= w_spm1;
                            {r_fy, r_fx} <= r_stack[w_spm1[AW-1:0]];
                            r_nb         <= 4'd1;
                        end else begin
                            if (w_fl_wr) begin
                                r_cells[w_nidx] <= r_cnt[w_nidx] + 4'd1;
                                r_rev           <= w_rev_after;
                            end
                            if (w_fl_push) r_sp <= r_sp + 1'b1;
                            r_nb <= (r_nb == 4'd8) ? 4'd0 : r_nb + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Neighbour-count table and reveal stack hold pure data and need no reset
    always_ff @(posedge clk_1ms) begin
        if (r_state == S_COUNT && !w_e_start)
            r_cnt[w_cidx] <= f_count(r_mines, int'(r_cx), int'(r_cy));
        if (w_stamp_go && !w_pmine && w_pcnt == 4'd0)
            r_stack[r_sp[AW-1:0]] <= {r_py, r_px};
        if (w_fl_push)
            r_stack[r_sp[AW-1:0]] <= {w_ny4, w_nx4};
    end

    always_comb begin
        rd_state = 4'd0;
        if (w_rin)
            rd_state = (r_state == S_LOSE && r_mines[w_ridx]) ? 4'd11 : r_cells[w_ridx];
    end

    assign posx     = r_px;
    assign posy     = r_py;
    assign state    = r_state;
    assign busy     = (r_state == S_COUNT) || (r_state == S_FLOOD);
    assign revealed = r_rev;
`ifdef FLAG_LIMIT_EN
    assign flags_left = r_flags;
`endif

endmodule

// File: tb/tb_mine_board_ctrl.sv
// Scoreboard bench for mine_board_ctrl on a 10x10 board: expected cell codes come from
// an independent breadth-first reveal model and are queued, then drained through rd_x/rd_y.
module tb_mine_board_ctrl;

    localparam int COLS = 10;
    localparam int ROWS = 10;
    localparam int N    = COLS * ROWS;
    localparam int AW   = $clog2(N);
    localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_ST = 4, B_MK = 5;

    logic          clk_1ms = 1'b0;
    logic          reset, start, left, right, up, down, stamp, mark;
    logic [N-1:0]  mines_in;
    logic [3:0]    rd_x, rd_y, rd_state, posx, posy;
    logic [2:0]    state;
    logic          busy;
    logic [AW:0]   revealed;
`ifdef FLAG_LIMIT_EN
    logic [AW:0]   flags_left;
`endif

    mine_board_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk_1ms(clk_1ms), .reset(reset), .start(start), .mines_in(mines_in),
        .left(left), .right(right), .up(up), .down(down), .stamp(stamp), .mark(mark),
        .rd_x(rd_x), .rd_y(rd_y), .rd_state(rd_state), .posx(posx), .posy(posy),
        .state(state), .busy(busy),
`ifdef FLAG_LIMIT_EN
        .flags_left(flags_left),
`endif
        .revealed(revealed)
    );

    always #5 clk_1ms = ~clk_1ms;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference model
    int m_code [N];
    bit m_mine [N];

    function automatic int m_count(input int x, input int y);
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < COLS &&
                    y + dy >= 0 && y + dy < ROWS && m_mine[(y + dy) * COLS + x + dx])
                    c++;
        return c;
    endfunction

    task automatic m_new(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            m_mine[i] = m[i];
            m_code[i] = 0;
        end
    endtask

    task automatic m_flood(input int sx, input int sy);
        int q[$];
        int c, cx, cy, nx, ny, k;
        k = sy * COLS + sx;
        m_code[k] = m_count(sx, sy) + 1;
        if (m_code[k] == 1) q.push_back(k);
        while (q.size() > 0) begin
            c  = q.pop_front();
            cx = c % COLS;
            cy = c / COLS;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                    nx = cx + dx;
                    ny = cy + dy;
                    if (!(dx == 0 && dy == 0) && nx >= 0 && nx < COLS && ny >= 0 && ny < ROWS) begin
                        k = ny * COLS + nx;
                        if (m_code[k] == 0 && !m_mine[k]) begin
                            m_code[k] = m_count(nx, ny) + 1;
                            if (m_code[k] == 1) q.push_back(k);
                        end
                    end
                end
        end
    endtask

    function automatic int m_revealed();
        int r = 0;
        for (int i = 0; i < N; i++)
            if (m_code[i] >= 1 && m_code[i] <= 9) r++;
        return r;
    endfunction

    // Scoreboard of expected read-port values
    typedef struct {
        int x;
        int y;
        int exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic sb_push(input int x, input int y, input int exp);
        sb_q.push_back('{x, y, exp});
    endtask

    task automatic sb_push_board(input bit lose);
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                sb_push(x, y, (lose && m_mine[y * COLS + x]) ? 11 : m_code[y * COLS + x]);
    endtask

    task automatic sb_drain(input string tag);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk_1ms);
            rd_x = 4'(e.x);
            rd_y = 4'(e.y);
            #1;
            check_eq($sformatf("%s(%0d,%0d)", tag, e.x, e.y), int'(rd_state), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic press(input int b);
        case (b)
            B_L:  left  = 1'b1;
            B_R:  right = 1'b1;
            B_U:  up    = 1'b1;
            B_D:  down  = 1'b1;
            B_ST: stamp = 1'b1;
            default: mark = 1'b1;
        endcase
        tick();
        {left, right, up, down, stamp, mark} = '0;
        tick();
    endtask

    task automatic start_game(input logic [N-1:0] m, output int ncyc);
        mines_in = m;
        start    = 1'b1;
        tick();
        start = 1'b0;
        ncyc  = 0;
        while (state == 3'd1 && ncyc < 1000) begin
            ncyc++;
            tick();
        end
        m_new(m);
    endtask

    task automatic wait_flood(input string tag);
        int n = 0;
        while (state == 3'd3 && n < 5000) begin
            n++;
            tick();
        end
        check_eq({tag, "_done_in_budget"}, int'(n < 5000), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] m;
        int ncyc;

        reset = 1'b1;
        start = 1'b0;
        {left, right, up, down, stamp, mark} = '0;
        mines_in = '0;
        rd_x = '0;
        rd_y = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_posx", int'(posx), 0);
        check_eq("rst_posy", int'(posy), 0);
        check_eq("rst_revealed", int'(revealed), 0);
        check_eq("rst_busy", int'(busy), 0);
        sb_push(0, 0, 0);
        sb_push(9, 9, 0);
        sb_drain("rst_cell");

        // Single mine at cell 0: count timing, single reveal, cursor wrap
        m = '0;
        m[0] = 1'b1;
        start_game(m, ncyc);
        check_eq("count_len", ncyc, N);
        check_eq("play_after_count", int'(state), 2);
        press(B_R);
        press(B_D);
        check_eq("move_x", int'(posx), 1);
        check_eq("move_y", int'(posy), 1);
        press(B_ST);
        check_eq("single_rev", int'(revealed), 1);
        check_eq("single_state", int'(state), 2);
        sb_push(1, 1, m_count(1, 1) + 1);
        sb_push(0, 0, 0);
        sb_push(2, 2, 0);
        sb_drain("single");
        press(B_L);
        press(B_L);
        check_eq("wrap_left", int'(posx), 9);
        press(B_U);
        press(B_U);
        check_eq("wrap_up", int'(posy), 9);
        press(B_R);
        check_eq("wrap_right", int'(posx), 0);

        // Full flood to a win
        start_game(m, ncyc);
        press(B_L);
        press(B_U);
        press(B_ST);
        check_eq("flood_state", int'(state), 3);
        check_eq("flood_busy", int'(busy), 1);
        wait_flood("flood");
        m_flood(9, 9);
        check_eq("win_state", int'(state), 5);
        check_eq("win_revealed", int'(revealed), m_revealed());
        sb_push_board(1'b0);
        sb_push(10, 0, 0);
        sb_push(0, 10, 0);
        sb_push(15, 15, 0);
        sb_drain("win");

        // Stamp on a mine
        m = '0;
        m[0] = 1'b1;
        m[15] = 1'b1;
        m[27] = 1'b1;
        start_game(m, ncyc);
        press(B_L);
        check_eq("lose_wrap_x", int'(posx), 9);
        press(B_R);
        repeat (5) press(B_R);
        press(B_D);
        check_eq("lose_x", int'(posx), 5);
        check_eq("lose_y", int'(posy), 1);
        press(B_ST);
        check_eq("lose_state", int'(state), 4);
        sb_push_board(1'b1);
        sb_drain("lose");

        // Flag toggling and stamp on a flag
        m = '0;
        m[0] = 1'b1;
        start_game(m, ncyc);
        repeat (3) press(B_R);
        repeat (3) press(B_D);
        press(B_MK);
        sb_push(3, 3, 10);
        sb_drain("mark1");
        press(B_MK);
        sb_push(3, 3, 0);
        sb_drain("mark2");
        press(B_MK);
        press(B_ST);
        check_eq("flag_stamp_rev", int'(revealed), 0);
        check_eq("flag_stamp_state", int'(state), 2);
        sb_push(3, 3, 10);
        sb_drain("flag_stamp");

        // Mine wall on column 5 with a flag inside the flood region
        m = '0;
        for (int y = 0; y < ROWS; y++) m[y * COLS + 5] = 1'b1;
        start_game(m, ncyc);
        press(B_R);
        press(B_R);
        press(B_D);
        press(B_D);
        press(B_MK);
        press(B_L);
        press(B_L);
        press(B_U);
        press(B_U);
        press(B_ST);
        wait_flood("wall");
        m_code[2 * COLS + 2] = 10;
        m_flood(0, 0);
        check_eq("wall_state", int'(state), 2);
        check_eq("wall_revealed", int'(revealed), m_revealed());
        sb_push_board(1'b0);
        sb_drain("wall");

        // Reset in the middle of a flood
        m = '0;
        m[0] = 1'b1;
        start_game(m, ncyc);
        press(B_L);
        press(B_ST);
        repeat (20) tick();
        check_eq("midflood_state", int'(state), 3);
        reset = 1'b1;
        tick();
        check_eq("abort_state", int'(state), 0);
        check_eq("abort_revealed", int'(revealed), 0);
        check_eq("abort_posx", int'(posx), 0);
        check_eq("abort_busy", int'(busy), 0);
        m_new('0);
        sb_push_board(1'b0);
        sb_drain("abort");
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
